// File: rtl/regfile_pkg.sv
// Shared constants and the writeback grant encoding for the register-file writeback block.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    // Identifies which writeback source won arbitration.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter between the ALU and LSU writeback sources.
// A grant is only ever given to a requesting source, so a raised grant bit is
// a completed handshake. last_grant moves only when a grant is given.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_alu,
    input  logic       req_lsu,
    output logic       grant_alu,
    output logic       grant_lsu,
    output grant_e     last_grant
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    assign last_grant = last_grant_q;

    // Grant selection: sole requester wins; on a tie the source not granted last wins.
    always_comb begin
        grant_alu    = 1'b0;
        grant_lsu    = 1'b0;
        last_grant_d = last_grant_q;
        if (!reset) begin
            if (req_alu && req_lsu) begin
                if (last_grant_q == GRANT_LSU) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else if (req_alu) begin
                grant_alu = 1'b1;
            end else if (req_lsu) begin
                grant_lsu = 1'b1;
            end
            if (grant_alu) begin
                last_grant_d = GRANT_ALU;
            end else if (grant_lsu) begin
                last_grant_d = GRANT_LSU;
            end
        end
    end

    // Last-grant state; reset to LSU so the first tie goes to the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback stage: arbitrates ALU/LSU results onto a single
// registered write port and tracks which registers have a pending write.
//
// Handshakes: a source offers a result by raising valid with rd/data stable;
// the result is taken in the cycle where valid and ready are both high. ready
// is combinational from the valids and never high for both sources at once.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int XLEN       = regfile_pkg::XLEN,
    parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [REG_ADDR_W-1:0]       issue_rd,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [REG_ADDR_W-1:0]       alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [REG_ADDR_W-1:0]       lsu_rd,
    input  logic [XLEN-1:0]             lsu_data,
    output logic                        write_en,
    output logic [REG_ADDR_W-1:0]       dst_addr,
    output logic [XLEN-1:0]             dst_data,
    output logic [(1<<REG_ADDR_W)-1:0]  busy,
    output logic                        wb_err
);

    localparam int NREGS = 1 << REG_ADDR_W;

    grant_e                 last_grant;
    logic                   accept;
    logic [REG_ADDR_W-1:0]  sel_rd;
    logic [XLEN-1:0]        sel_data;
    logic                   sel_nonzero;
    logic [NREGS-1:0]       busy_d;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_alu    (alu_valid),
        .req_lsu    (lsu_valid),
        .grant_alu  (alu_ready),
        .grant_lsu  (lsu_ready),
        .last_grant (last_grant)
    );

    // Select the accepted source's destination and value.
    always_comb begin
        accept      = alu_ready | lsu_ready;
        sel_rd      = lsu_ready ? lsu_rd : alu_rd;
        sel_data    = lsu_ready ? lsu_data : alu_data;
        sel_nonzero = (sel_rd != '0);
    end

    // Next pending bitmap: writeback clears, issue sets afterwards so it wins; x0 never pending.
    always_comb begin
        busy_d = busy;
        if (accept && sel_nonzero) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output write port, pending bitmap and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_en <= 1'b0;
            dst_addr <= '0;
            dst_data <= '0;
            busy     <= '0;
            wb_err   <= 1'b0;
        end else begin
            write_en <= accept && sel_nonzero;
            if (accept) begin
                dst_addr <= sel_rd;
                dst_data <= sel_data;
            end
            busy <= busy_d;
            if (accept && sel_nonzero && !busy[sel_rd]) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with hand-computed expected values.
module tb_regfile_writeback;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 1 << REG_ADDR_W;

    logic                   clk;
    logic                   reset;
    logic                   issue_valid;
    logic [REG_ADDR_W-1:0]  issue_rd;
    logic                   alu_valid;
    logic                   alu_ready;
    logic [REG_ADDR_W-1:0]  alu_rd;
    logic [XLEN-1:0]        alu_data;
    logic                   lsu_valid;
    logic                   lsu_ready;
    logic [REG_ADDR_W-1:0]  lsu_rd;
    logic [XLEN-1:0]        lsu_data;
    logic                   write_en;
    logic [REG_ADDR_W-1:0]  dst_addr;
    logic [XLEN-1:0]        dst_data;
    logic [NREGS-1:0]       busy;
    logic                   wb_err;

    int n_checks;
    int n_errors;

    regfile_writeback #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .write_en    (write_en),
        .dst_addr    (dst_addr),
        .dst_data    (dst_data),
        .busy        (busy),
        .wb_err      (wb_err)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_rd    = '0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [REG_ADDR_W-1:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset = 1'b1;

        // Reset state, with both sources offering results during reset.
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd2;
        issue_valid = 1'b1;
        issue_rd    = 5'd6;
        tick();
        tick();
        check_val("rst_alu_ready", alu_ready, 0);
        check_val("rst_lsu_ready", lsu_ready, 0);
        check_val("rst_write_en", write_en, 0);
        check_val("rst_dst_addr", dst_addr, 0);
        check_val("rst_dst_data", dst_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_wb_err", wb_err, 0);
        idle_inputs();
        reset = 1'b0;
        tick();

        // Basic issue then ALU writeback.
        issue(5'd5);
        check_val("iss5_busy", busy, 64'h20);
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        #1;
        check_val("wb5_alu_ready", alu_ready, 1);
        check_val("wb5_lsu_ready", lsu_ready, 0);
        tick();
        idle_inputs();
        check_val("wb5_write_en", write_en, 1);
        check_val("wb5_dst_addr", dst_addr, 5);
        check_val("wb5_dst_data", dst_data, 32'hDEADBEEF);
        check_val("wb5_busy", busy, 0);
        check_val("wb5_wb_err", wb_err, 0);
        tick();
        check_val("idle_write_en", write_en, 0);
        check_val("idle_dst_addr", dst_addr, 5);
        check_val("idle_dst_data", dst_data, 32'hDEADBEEF);

        // Tie after reset: ALU first, then LSU.
        do_reset();
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h11;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd2;
        lsu_data  = 32'h22;
        #1;
        check_val("tie1_alu_ready", alu_ready, 1);
        check_val("tie1_lsu_ready", lsu_ready, 0);
        tick();
        check_val("tie1_write_en", write_en, 1);
        check_val("tie1_dst_addr", dst_addr, 1);
        check_val("tie1_dst_data", dst_data, 32'h11);
        check_val("tie2_alu_ready", alu_ready, 0);
        check_val("tie2_lsu_ready", lsu_ready, 1);
        tick();
        idle_inputs();
        check_val("tie2_write_en", write_en, 1);
        check_val("tie2_dst_addr", dst_addr, 2);
        check_val("tie2_dst_data", dst_data, 32'h22);
        check_val("tie_wb_err", wb_err, 1);

        // rd=0 writeback is accepted but never written.
        do_reset();
        issue(5'd4);
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'hFFFFFFFF;
        #1;
        check_val("x0_alu_ready", alu_ready, 1);
        tick();
        idle_inputs();
        check_val("x0_write_en", write_en, 0);
        check_val("x0_busy", busy, 64'h10);
        check_val("x0_wb_err", wb_err, 0);

        // Same-edge issue and writeback to rd=7: set wins.
        issue(5'd7);
        check_val("iss7_busy", busy, 64'h90);
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        lsu_valid   = 1'b1;
        lsu_rd      = 5'd7;
        lsu_data    = 32'h77;
        #1;
        check_val("same7_lsu_ready", lsu_ready, 1);
        tick();
        idle_inputs();
        check_val("same7_write_en", write_en, 1);
        check_val("same7_dst_addr", dst_addr, 7);
        check_val("same7_busy", busy, 64'h90);
        check_val("same7_wb_err", wb_err, 0);

        // Writeback to a non-pending register raises a sticky error.
        lsu_valid = 1'b1;
        lsu_rd    = 5'd9;
        lsu_data  = 32'h99;
        tick();
        idle_inputs();
        check_val("err9_write_en", write_en, 1);
        check_val("err9_dst_addr", dst_addr, 9);
        check_val("err9_dst_data", dst_data, 32'h99);
        check_val("err9_wb_err", wb_err, 1);
        tick();
        tick();
        check_val("err9_sticky", wb_err, 1);
        check_val("err9_busy", busy, 64'h90);

        // Reset mid-operation discards pending state and blocks the handshake.
        issue(5'd3);
        check_val("iss3_busy", busy, 64'h98);
        reset     = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h33;
        #1;
        check_val("midrst_alu_ready", alu_ready, 0);
        tick();
        check_val("midrst_write_en", write_en, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_wb_err", wb_err, 0);
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
